irq_arbiter: RTL and testbench
==============================

# irq_arbiter

Interrupt arbiter between the system bus devices (Timer instances and other peripherals) and the CPU's CP0 interrupt input. It latches or mirrors up to N_SRC device IRQ lines, applies a software mask and fixed priority, and presents one request plus a source ID to the CPU. It holds the request until acknowledged and blocks further requests until the handler returns. Software configures it through a 4-word bus window with the same RD/WD/WE/ADDR style as the other bus devices.

## Interface
- N_SRC, 6, number of device IRQ sources (1..8); index 0 has highest priority
- CLK  in  1  clock
- RST  in  1  reset, synchronous, active-high
- ADDR  in  2  word select: 0 MASK, 1 PEND, 2 EDGE, 3 STATUS (byte addr = base + ADDR*4)
- WE  in  1  bus write enable
- WD  in  32  bus write data
- RD  out  32  bus read data, combinational from ADDR
- SRC  in  N_SRC  device IRQ lines (e.g. Timer IRQ), synchronous to CLK
- INTACK  in  1  one-cycle pulse: CPU has entered the handler for the current request
- IRET  in  1  one-cycle pulse: CPU executed eret
- IRQ  out  1  registered interrupt request to CP0
- IRQ_ID  out  3  registered index of the source being requested or serviced

## Operation
- Registers, all reset to 0: MASK[N_SRC-1:0] (1 = enabled), EDGE[N_SRC-1:0] (1 = rising-edge, 0 = level), PEND[N_SRC-1:0], SRC_D (previous SRC), state, IRQ, IRQ_ID.
- Reads: MASK, PEND and EDGE are zero-extended. STATUS = {24'b0, state[1:0] at bits 7:6, 3'b0, IRQ_ID at bits 2:0}. Writes to STATUS are ignored.
- Writes: MASK <= WD[N_SRC-1:0]; EDGE <= WD[N_SRC-1:0]. A write of 1 to a PEND bit clears it for edge sources; it has no effect on level sources.
- Edge source i: PEND[i] is set when SRC[i] & ~SRC_D[i]. It is cleared by a write-1 or by INTACK while IRQ_ID == i. A set and a clear in the same cycle: set wins.
- Level source i: PEND[i] = SRC[i] every cycle. It is not latched.
- Active vector A = PEND & MASK. The winner is the lowest set index of A.
- Bus writes and FSM updates happen in the same cycle. The FSM sees pre-write register values.
- FSM, encoded as IDLE=0, REQ=1, SERVICE=2:
  - IDLE: if A != 0, then IRQ_ID <= winner, IRQ <= 1, go to REQ.
  - REQ: IRQ_ID is frozen; a higher-priority arrival does not preempt.
    - INTACK: IRQ <= 0, go to SERVICE.
    - Otherwise, if A[IRQ_ID] == 0 (masked, cleared or level dropped): IRQ <= 0, go to IDLE. IRQ_ID keeps its value.
  - SERVICE: IRQ stays 0 and new pending bits accumulate. IRET goes to IDLE.
- INTACK outside REQ and IRET outside SERVICE are ignored, with no state change.
- RST mid-operation returns everything to reset values at that edge, including any pending edges. SRC_D <= 0, so a SRC line held high through reset registers as an edge on the first cycle after reset.

## Timing
- Edge source: SRC high at edge k (low at k-1) -> PEND set after edge k -> IRQ = 1 after edge k+1. Latency is 2 cycles.
- Level source: SRC high at edge k -> IRQ = 1 after edge k. Latency is 1 cycle.
- INTACK sampled at edge k -> IRQ = 0 and state SERVICE after edge k. For an edge source, the PEND bit is cleared at the same edge.
- IRET at edge k -> IDLE after k. If A != 0, IRQ rises again after k+1. The minimum IRQ gap is 2 cycles.
- A MASK write that clears the requested bit in REQ takes 2 edges to drop IRQ: one to update MASK, one for the FSM to see it.
- RD is valid in the same cycle as ADDR. A read in the same cycle as a write returns the old value.

## Test plan
- Reset, then read all four addresses -> all 0, IRQ = 0, IRQ_ID = 0.
- MASK = 0x3F, EDGE = 0x01, pulse SRC[0] for 1 cycle -> PEND = 0x01, IRQ = 1 two cycles later with IRQ_ID = 0. INTACK -> IRQ = 0, PEND = 0, STATUS[7:6] = 2. IRET -> STATUS[7:6] = 0.
- EDGE = 0x3F, MASK = 0x3F, SRC[4] and SRC[2] rise in the same cycle -> IRQ_ID = 2. INTACK, IRET -> IRQ returns 2 cycles after IRET with IRQ_ID = 4.
- Level SRC[1] high, MASK = 0x02 -> IRQ = 1. SRC[1] falls before INTACK -> IRQ = 0 one cycle later and state IDLE. A later INTACK is ignored.
- Edge SRC[3] pending in REQ, write MASK = 0 -> IRQ drops 2 edges after the write and PEND[3] stays 1. Rewrite MASK = 0x08 -> IRQ returns with IRQ_ID = 3.
- Write PEND = 0x01 in the same cycle SRC[0] rises -> PEND[0] = 1 (set wins). Assert RST while in SERVICE -> all registers 0 next cycle.

Source files
------------

// File: rtl/irq_arbiter.sv
// Interrupt arbiter: masks and prioritises device IRQ lines and presents one request plus
// a source ID to CP0, holding it until INTACK and blocking new requests until IRET.
module irq_arbiter #(
  parameter int N_SRC = 6
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [1:0]       ADDR,
  input  logic             WE,
  input  logic [31:0]      WD,
  output logic [31:0]      RD,
  input  logic [N_SRC-1:0] SRC,
  input  logic             INTACK,
  input  logic             IRET,
  output logic             IRQ,
  output logic [2:0]       IRQ_ID
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [N_SRC-1:0] mask_q, mask_d;
  logic [N_SRC-1:0] edge_q, edge_d;
  logic [N_SRC-1:0] pend_q, pend_d;
  logic [N_SRC-1:0] src_d_q;
  logic             irq_q, irq_d;
  logic [2:0]       irq_id_q, irq_id_d;

  logic [N_SRC-1:0] pend_view, active, rise, wr_clr, ack_clr, edge_pend;
  logic [2:0]       winner;
  logic             cur_active;
  logic             wr_mask, wr_pend, wr_edge, ack_ok;
  logic             unused_wd;

  assign wr_mask   = WE && (ADDR == 2'd0);
  assign wr_pend   = WE && (ADDR == 2'd1);
  assign wr_edge   = WE && (ADDR == 2'd2);
  assign ack_ok    = INTACK && (state_q == REQ);
  assign unused_wd = ^WD[31:N_SRC];

  // Level sources bypass the latch so they request one cycle after SRC rises.
  assign pend_view = (pend_q & edge_q) | (SRC & ~edge_q);
  assign active    = pend_view & mask_q;
  assign rise      = SRC & ~src_d_q;
  assign wr_clr    = wr_pend ? WD[N_SRC-1:0] : '0;

  always_comb begin
    winner     = '0;
    cur_active = 1'b0;
    ack_clr    = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (active[i]) winner = 3'(i);
    end
    for (int i = 0; i < N_SRC; i++) begin
      if (irq_id_q == 3'(i)) begin
        cur_active = active[i];
        ack_clr[i] = ack_ok;
      end
    end
  end

  // A new rising edge wins over a same-cycle clear.
  assign edge_pend = rise | (pend_q & ~(wr_clr | ack_clr));

  always_comb begin
    pend_d = (edge_pend & edge_q) | (SRC & ~edge_q);
    mask_d = wr_mask ? WD[N_SRC-1:0] : mask_q;
    edge_d = wr_edge ? WD[N_SRC-1:0] : edge_q;
  end

  always_comb begin
    state_d  = state_q;
    irq_d    = irq_q;
    irq_id_d = irq_id_q;
    case (state_q)
      IDLE: begin
        if (|active) begin
          irq_id_d = winner;
          irq_d    = 1'b1;
          state_d  = REQ;
        end
      end
      REQ: begin
        if (INTACK) begin
          irq_d   = 1'b0;
          state_d = SERVICE;
        end else if (!cur_active) begin
          irq_d   = 1'b0;
          state_d = IDLE;
        end
      end
      SERVICE: begin
        irq_d = 1'b0;
        if (IRET) state_d = IDLE;
      end
      default: begin
        irq_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      mask_q   <= '0;
      edge_q   <= '0;
      pend_q   <= '0;
      src_d_q  <= '0;
      irq_q    <= 1'b0;
      irq_id_q <= '0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      edge_q   <= edge_d;
      pend_q   <= pend_d;
      src_d_q  <= SRC;
      irq_q    <= irq_d;
      irq_id_q <= irq_id_d;
    end
  end

  always_comb begin
    RD = '0;
    case (ADDR)
      2'd0:    RD = {{(32 - N_SRC){1'b0}}, mask_q};
      2'd1:    RD = {{(32 - N_SRC){1'b0}}, pend_view};
      2'd2:    RD = {{(32 - N_SRC){1'b0}}, edge_q};
      default: RD = {24'b0, state_q, 3'b0, irq_id_q};
    endcase
  end

  assign IRQ    = irq_q;
  assign IRQ_ID = irq_id_q;

endmodule

// File: tb/tb_irq_arbiter.sv
// Bench for irq_arbiter: directed scenarios with fixed expected values, then random
// traffic compared every cycle against a behavioural model of the arbiter.
module tb_irq_arbiter;

  localparam int N = 6;

  logic          clk;
  logic          rst;
  logic [1:0]    addr;
  logic          we;
  logic [31:0]   wd;
  logic [31:0]   rd;
  logic [N-1:0]  src;
  logic          intack;
  logic          iret;
  logic          irq;
  logic [2:0]    irq_id;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q[$];

  irq_arbiter #(.N_SRC(N)) dut (
    .CLK(clk), .RST(rst), .ADDR(addr), .WE(we), .WD(wd), .RD(rd),
    .SRC(src), .INTACK(intack), .IRET(iret), .IRQ(irq), .IRQ_ID(irq_id)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // behavioural model: latched edge bits, mask/edge config and a phase number
  bit m_mask[N];
  bit m_edge[N];
  bit m_latch[N];
  bit m_prev[N];
  int m_phase;
  int m_id;
  bit m_irq;

  function automatic bit m_pending(int i);
    return m_edge[i] ? m_latch[i] : src[i];
  endfunction

  function automatic logic [31:0] m_read();
    int v = 0;
    case (addr)
      2'd0: for (int i = 0; i < N; i++) v += m_mask[i] * (1 << i);
      2'd1: for (int i = 0; i < N; i++) v += m_pending(i) * (1 << i);
      2'd2: for (int i = 0; i < N; i++) v += m_edge[i] * (1 << i);
      default: v = m_phase * 64 + m_id;
    endcase
    return 32'(v);
  endfunction

  task automatic m_update();
    bit act[N];
    bit nl[N];
    int first = -1;
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_mask[i] = 0; m_edge[i] = 0; m_latch[i] = 0; m_prev[i] = 0;
      end
      m_phase = 0; m_id = 0; m_irq = 0;
      return;
    end
    for (int i = 0; i < N; i++) begin
      act[i] = m_pending(i) && m_mask[i];
      if (act[i] && first < 0) first = i;
      if (src[i] && !m_prev[i]) nl[i] = 1;
      else if ((we && addr == 2'd1 && wd[i]) || (intack && m_phase == 1 && m_id == i)) nl[i] = 0;
      else nl[i] = m_latch[i];
    end
    if (m_phase == 0 && first >= 0) begin
      m_id = first; m_irq = 1; m_phase = 1;
    end else if (m_phase == 1 && intack) begin
      m_irq = 0; m_phase = 2;
    end else if (m_phase == 1 && !act[m_id]) begin
      m_irq = 0; m_phase = 0;
    end else if (m_phase == 2 && iret) begin
      m_phase = 0;
    end
    for (int i = 0; i < N; i++) begin
      m_latch[i] = m_edge[i] ? nl[i] : src[i];
      if (we && addr == 2'd0) m_mask[i] = wd[i];
      if (we && addr == 2'd2) m_edge[i] = wd[i];
      m_prev[i] = src[i];
    end
  endtask

  // scoreboard compare
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    logic [3:0] e;
    #1;
    chk("rd_model", rd, m_read());
    @(posedge clk);
    m_update();
    exp_q.push_back({m_irq, 3'(m_id)});
    #1;
    e = exp_q.pop_front();
    chk("irq_model", {28'b0, irq, irq_id}, {28'b0, e});
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    addr = a; we = 1'b1; wd = d;
    tick();
    we = 1'b0; wd = '0;
  endtask

  task automatic peek(input logic [1:0] a, input string tag, input logic [31:0] exp);
    addr = a;
    #1;
    chk(tag, rd, exp);
  endtask

  task automatic out(input string tag, input logic ei, input logic [2:0] eid);
    chk(tag, {28'b0, irq, irq_id}, {28'b0, ei, eid});
  endtask

  initial begin
    logic [N-1:0] flip;
    rst = 1'b1; addr = '0; we = 1'b0; wd = '0; src = '0; intack = 1'b0; iret = 1'b0;
    tick();
    rst = 1'b0;
    peek(2'd0, "reset_mask", 32'h0);
    peek(2'd1, "reset_pend", 32'h0);
    peek(2'd2, "reset_edge", 32'h0);
    peek(2'd3, "reset_status", 32'h0);
    out("reset_irq", 1'b0, 3'd0);

    // single edge source
    wr(2'd0, 32'h3F);
    wr(2'd2, 32'h01);
    src = 6'h01; tick(); src = 6'h00;
    out("edge_lat1", 1'b0, 3'd0);
    peek(2'd1, "edge_pend_set", 32'h01);
    tick();
    out("edge_lat2", 1'b1, 3'd0);
    intack = 1'b1; tick(); intack = 1'b0;
    out("ack_irq", 1'b0, 3'd0);
    peek(2'd1, "ack_pend_clr", 32'h0);
    peek(2'd3, "ack_service", 32'h80);
    iret = 1'b1; tick(); iret = 1'b0;
    peek(2'd3, "iret_idle", 32'h0);

    // two simultaneous edges, priority then the loser after IRET
    wr(2'd2, 32'h3F);
    src = 6'h14; tick(); tick();
    out("prio_first", 1'b1, 3'd2);
    intack = 1'b1; tick(); intack = 1'b0;
    peek(2'd1, "prio_pend_left", 32'h10);
    iret = 1'b1; src = 6'h00; tick(); iret = 1'b0;
    out("prio_gap", 1'b0, 3'd2);
    tick();
    out("prio_second", 1'b1, 3'd4);
    intack = 1'b1; tick(); intack = 1'b0;
    iret = 1'b1; tick(); iret = 1'b0;

    // level source dropping before acknowledge
    wr(2'd2, 32'h00);
    wr(2'd0, 32'h02);
    src = 6'h02; tick();
    out("level_req", 1'b1, 3'd1);
    src = 6'h00; tick();
    out("level_drop", 1'b0, 3'd1);
    peek(2'd3, "level_idle", 32'h01);
    intack = 1'b1; tick(); intack = 1'b0;
    peek(2'd3, "stray_ack", 32'h01);
    out("stray_ack_irq", 1'b0, 3'd1);

    // masking a pending edge source while requested
    wr(2'd2, 32'h3F);
    wr(2'd0, 32'h08);
    src = 6'h08; tick();
    out("mask_lat1", 1'b0, 3'd1);
    tick();
    out("mask_req", 1'b1, 3'd3);
    wr(2'd0, 32'h00);
    out("mask_edge1", 1'b1, 3'd3);
    tick();
    out("mask_edge2", 1'b0, 3'd3);
    peek(2'd1, "mask_pend_kept", 32'h08);
    wr(2'd0, 32'h08);
    out("unmask_edge1", 1'b0, 3'd3);
    tick();
    out("unmask_req", 1'b1, 3'd3);
    intack = 1'b1; tick(); intack = 1'b0;
    iret = 1'b1; src = 6'h00; tick(); iret = 1'b0;

    // set wins over write-1 clear, then reset from SERVICE
    addr = 2'd1; we = 1'b1; wd = 32'h01; src = 6'h01; tick(); we = 1'b0; wd = '0;
    peek(2'd1, "set_wins", 32'h01);
    wr(2'd0, 32'h01);
    tick();
    out("rst_pre_req", 1'b1, 3'd0);
    intack = 1'b1; src = 6'h21; tick(); intack = 1'b0;
    peek(2'd3, "rst_pre_svc", 32'h80);
    peek(2'd1, "rst_pre_pend", 32'h20);
    rst = 1'b1; src = 6'h00; tick(); rst = 1'b0;
    peek(2'd0, "rst_mask", 32'h0);
    peek(2'd1, "rst_pend", 32'h0);
    peek(2'd2, "rst_edge", 32'h0);
    peek(2'd3, "rst_status", 32'h0);
    out("rst_irq", 1'b0, 3'd0);

    // random traffic against the model
    for (int n = 0; n < 600; n++) begin
      addr   = 2'($urandom_range(0, 3));
      we     = ($urandom_range(0, 3) == 0);
      wd     = $urandom;
      flip   = '0;
      if ($urandom_range(0, 2) == 0) flip[$urandom_range(0, N - 1)] = 1'b1;
      src    = src ^ flip;
      intack = ($urandom_range(0, 2) == 0);
      iret   = ($urandom_range(0, 3) == 0);
      rst    = ($urandom_range(0, 149) == 0);
      tick();
    end
    rst = 1'b0; we = 1'b0; intack = 1'b0; iret = 1'b0;

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
